// File: rtl/mul4_eval_pkg.sv
// Shared definitions for evaluating evolved 2x2-bit multiplier candidates:
// lane count, scorer FSM states and the golden 2x2 product.
package mul4_eval_pkg;

  localparam int LANES_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Product bits of a 2-bit by 2-bit multiply, returned as {p3,p2,p1,p0}.
  function automatic logic [3:0] golden_product(input logic [1:0] a, input logic [1:0] b);
    logic all4;
    all4 = a[1] & a[0] & b[1] & b[0];
    return {all4, (a[1] & b[1]) ^ all4, (a[1] & b[0]) ^ (a[0] & b[1]), a[0] & b[0]};
  endfunction

endpackage

// File: rtl/lane_popcount.sv
// Combinational population count of a W-bit vector.
module lane_popcount #(
  parameter int W = 16
) (
  input  logic [W-1:0]             vec,
  output logic [$clog2(W+1)-1:0]   count
);

  localparam int CW = $clog2(W + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/mul4_fitness_scorer.sv
// Scores a 2x2 multiplier candidate over multi-beat bit-plane test vectors:
// match stage, popcount stage, then saturating score/hit accumulation.
module mul4_fitness_scorer
  import mul4_eval_pkg::*;
#(
  parameter int LANES   = LANES_DEFAULT,
  parameter int SCORE_W = 16,
  parameter int HIT_W   = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [LANES-1:0]   a1,
  input  logic [LANES-1:0]   a0,
  input  logic [LANES-1:0]   b1,
  input  logic [LANES-1:0]   b0,
  input  logic [LANES-1:0]   y3,
  input  logic [LANES-1:0]   y2,
  input  logic [LANES-1:0]   y1,
  input  logic [LANES-1:0]   y0,
  output logic [SCORE_W-1:0] score,
  output logic [HIT_W-1:0]   hits,
  output logic               busy,
  output logic               done
);

  localparam int BITS_W = $clog2(4 * LANES + 1);
  localparam int LHIT_W = $clog2(LANES + 1);
  localparam logic [31:0] SCORE_MAX = (32'd1 << SCORE_W) - 32'd1;
  localparam logic [31:0] HIT_MAX   = (32'd1 << HIT_W) - 32'd1;

  state_e state_q, state_d;

  logic [LANES-1:0] match3, match2, match1, match0;
  logic [LANES-1:0] m3_q, m2_q, m1_q, m0_q;
  logic [LANES-1:0] m3_d, m2_d, m1_d, m0_d;
  logic             s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic             s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
  logic [BITS_W-1:0] pop_bits, beat_bits_q, beat_bits_d;
  logic [LHIT_W-1:0] pop_hits, beat_hits_q, beat_hits_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [HIT_W-1:0]   hits_q, hits_d;
  logic               done_q, done_d;
  logic               accept;
  logic [31:0]        score_sum, hits_sum;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [3:0] prod;
      assign prod       = golden_product({a1[gi], a0[gi]}, {b1[gi], b0[gi]});
      assign match3[gi] = ~(y3[gi] ^ prod[3]);
      assign match2[gi] = ~(y2[gi] ^ prod[2]);
      assign match1[gi] = ~(y1[gi] ^ prod[1]);
      assign match0[gi] = ~(y0[gi] ^ prod[0]);
    end
  endgenerate

  lane_popcount #(.W(4 * LANES)) u_pop_bits (
    .vec   ({m3_q, m2_q, m1_q, m0_q}),
    .count (pop_bits)
  );

  lane_popcount #(.W(LANES)) u_pop_hits (
    .vec   (m3_q & m2_q & m1_q & m0_q),
    .count (pop_hits)
  );

  assign in_ready = (state_q == ACCUM);
  assign busy     = (state_q == ACCUM) || (state_q == DRAIN);
  assign done     = done_q;
  assign score    = score_q;
  assign hits     = hits_q;
  assign accept   = in_valid && in_ready;

  always_comb begin
    m3_d        = match3;
    m2_d        = match2;
    m1_d        = match1;
    m0_d        = match0;
    s1_valid_d  = accept;
    s1_last_d   = accept && in_last;
    s2_valid_d  = s1_valid_q;
    s2_last_d   = s1_last_q;
    beat_bits_d = pop_bits;
    beat_hits_d = pop_hits;
    state_d     = state_q;
    score_d     = score_q;
    hits_d      = hits_q;
    done_d      = 1'b0;

    // Widened sums so the saturation test sees any carry out of the accumulator.
    score_sum = 32'(score_q) + 32'(beat_bits_q);
    hits_sum  = 32'(hits_q) + 32'(beat_hits_q);
    if (s2_valid_q) begin
      score_d = (score_sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(score_sum);
      hits_d  = (hits_sum > HIT_MAX) ? HIT_W'(HIT_MAX) : HIT_W'(hits_sum);
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = ACCUM;
          score_d = '0;
          hits_d  = '0;
        end
      end
      ACCUM: begin
        if (accept && in_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (s2_valid_q && s2_last_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      m3_q        <= '0;
      m2_q        <= '0;
      m1_q        <= '0;
      m0_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      beat_bits_q <= '0;
      beat_hits_q <= '0;
      score_q     <= '0;
      hits_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      m3_q        <= m3_d;
      m2_q        <= m2_d;
      m1_q        <= m1_d;
      m0_q        <= m0_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      beat_bits_q <= beat_bits_d;
      beat_hits_q <= beat_hits_d;
      score_q     <= score_d;
      hits_q      <= hits_d;
      done_q      <= done_d;
    end
  end

endmodule
